rng_share_scheduler: RTL

RNG_SHARE_SCHEDULER -- requirements
Module: rng_share_scheduler

---
 rtl/qec_channel_pkg.sv | 5 +
 rtl/rng_share_scheduler_rr_arbiter.sv | 28 ++
 rtl/rng_share_scheduler.sv | 81 ++++++++
 3 files changed

// File: rtl/qec_channel_pkg.sv
// qec_channel_pkg: shared FSM state encoding and PRNG word width for the error-stream scheduler
package qec_channel_pkg;
  localparam int RNG_WIDTH = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, FILL, DONE} state_e;
endpackage

// File: rtl/rng_share_scheduler_rr_arbiter.sv
// rr_arbiter: picks the first set request at or after ptr, wrapping around
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          any
);
  logic [IW-1:0] idx;
  always_comb begin
    grant_idx = '0;
    grant_oh = '0;
    any = 1'b0;
    idx = '0;
    // scanning from the far end lets the nearest request to ptr win last
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        grant_idx = idx;
        any = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) grant_oh[i] = any && (grant_idx == IW'(i));
  end
endmodule

// File: rtl/rng_share_scheduler.sv
// rng_share_scheduler: time-shares one PRNG among channels, filling each granted channel's error vector
module rng_share_scheduler
  import qec_channel_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int MEASUREMENT_ROUNDS = 5,
  parameter int THRESH_WIDTH = 10
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_CHANNELS-1:0]                    ch_req,
  input  logic [THRESH_WIDTH-1:0]                    threshold,
  output logic                                       rng_next,
  input  logic [RNG_WIDTH-1:0]                       rng_r,
  input  logic                                       rng_valid,
  output logic [NUM_CHANNELS*MEASUREMENT_ROUNDS-1:0] ch_errors,
  output logic [NUM_CHANNELS-1:0]                    ch_done,
  output logic                                       busy
);
  localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CW = $clog2(MEASUREMENT_ROUNDS + 1);
  state_e state, state_nx;
  logic [IW-1:0] rr_ptr, grant, arb_idx;
  logic [NUM_CHANNELS-1:0] arb_oh, grant_oh;
  logic arb_any, last, hit;
  logic [CW-1:0] cnt;
  logic [THRESH_WIDTH-1:0] thr;
  logic [MEASUREMENT_ROUNDS-1:0] shadow, fill_vec;
  logic unused_rng;
  assign unused_rng = ^rng_r[RNG_WIDTH-THRESH_WIDTH-1:0];
  rr_arbiter #(.N(NUM_CHANNELS), .IW(IW)) u_arb (
    .req(ch_req),
    .ptr(rr_ptr),
    .grant_oh(arb_oh),
    .grant_idx(arb_idx),
    .any(arb_any)
  );
  assign last = cnt == CW'(MEASUREMENT_ROUNDS - 1);
  assign hit = rng_r[RNG_WIDTH-1 -: THRESH_WIDTH] < thr;
  always_comb begin
    fill_vec = shadow;
    fill_vec[cnt] = hit;
    state_nx = state == IDLE  ? (arb_any ? ISSUE : IDLE) :
               state == ISSUE ? FILL :
               state == FILL  ? ((rng_valid && last) ? DONE : FILL) : IDLE;
    rng_next = state == ISSUE || (state == FILL && rng_valid && !last);
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      grant <= '0;
      grant_oh <= '0;
      thr <= '0;
      shadow <= '0;
      ch_errors <= '0;
      ch_done <= '0;
    end else begin
      state <= state_nx;
      ch_done <= '0;
      if (state == IDLE && arb_any) begin
        grant <= arb_idx;
        grant_oh <= arb_oh;
        thr <= threshold;
        cnt <= '0;
      end
      if (state == FILL && rng_valid) begin
        shadow <= fill_vec;
        cnt <= cnt + 1'b1;
      end
      // the final word is merged on the way in so the slice and ch_done appear together in DONE
      if (state == FILL && rng_valid && last) begin
        ch_errors[int'(grant)*MEASUREMENT_ROUNDS +: MEASUREMENT_ROUNDS] <= fill_vec;
        ch_done <= grant_oh;
        rr_ptr <= (grant == IW'(NUM_CHANNELS - 1)) ? '0 : grant + 1'b1;
      end
    end
  end
endmodule
